// File: rtl/reset_seq_pkg.sv
// Shared state encodings and counter sizing for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    S_START   = 2'd0,
    S_RESET   = 2'd1,
    S_RELEASE = 2'd2,
    S_IDLE    = 2'd3
  } state_t;

  // Wide enough to hold the largest terminal count without wrapping.
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser; flops take RST_VAL asynchronously when i_rst_n falls.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta, r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// Power-up / soft reset sequencer: settle, hold all channels, then release
// channels one by one in ascending order, gated on a synchronised PLL lock.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int START_DLY = 256,
  parameter int HOLD_CYC  = 16,
  parameter int STAGGER   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pll_locked,
  input  logic              soft_req,
  output logic [NUM_CH-1:0] reset,
  output logic              reset_done
);

  localparam int CW = cnt_w(START_DLY, HOLD_CYC, STAGGER);
  localparam logic [CW-1:0]     C_START = CW'(START_DLY - 1);
  localparam logic [CW-1:0]     C_HOLD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0]     C_STAG  = CW'(STAGGER - 1);
  localparam logic [NUM_CH-1:0] ALL1    = '1;

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $fatal(1, "reset_sequencer: NUM_CH out of range 1..16");
  end
  if (START_DLY < 1) begin : g_bad_start_dly
    $fatal(1, "reset_sequencer: START_DLY must be >= 1");
  end
  if (HOLD_CYC < 1) begin : g_bad_hold_cyc
    $fatal(1, "reset_sequencer: HOLD_CYC must be >= 1");
  end
  if (STAGGER < 1) begin : g_bad_stagger
    $fatal(1, "reset_sequencer: STAGGER must be >= 1");
  end

  logic w_rst_n_s, w_lock_s;

  // Constant-1 input: async assert on reset_n low, synchronous release.
  sync_2ff #(.RST_VAL(1'b0)) u_rst_sync (
    .i_clk  (clk),
    .i_rst_n(reset_n),
    .i_d    (1'b1),
    .o_q    (w_rst_n_s)
  );

  sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
    .i_clk  (clk),
    .i_rst_n(reset_n),
    .i_d    (pll_locked),
    .o_q    (w_lock_s)
  );

  state_t            r_state, w_nxt_state;
  logic [CW-1:0]     r_cnt, w_nxt_cnt;
  logic [NUM_CH-1:0] r_rst, w_nxt_rst;
  logic              r_done, w_nxt_done;

  always_ff @(posedge clk or negedge w_rst_n_s) begin
    if (!w_rst_n_s) begin
      r_state <= S_START;
      r_cnt   <= '0;
      r_rst   <= ALL1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_rst   <= w_nxt_rst;
      r_done  <= w_nxt_done;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_rst   = r_rst;
    w_nxt_done  = r_done;
    case (r_state)
      S_START: begin
        w_nxt_rst = ALL1;
        if (!w_lock_s || r_cnt == C_START) begin
          w_nxt_state = S_RESET;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
      S_RESET: begin
        w_nxt_rst = ALL1;
        if (w_lock_s) begin
          if (r_cnt == C_HOLD) begin
            // Shifting the all-ones vector drops channel 0; with one channel
            // this empties the vector and we go straight to idle.
            w_nxt_rst   = ALL1 << 1;
            w_nxt_cnt   = '0;
            w_nxt_state = (w_nxt_rst == '0) ? S_IDLE : S_RELEASE;
            w_nxt_done  = (w_nxt_rst == '0);
          end else begin
            w_nxt_cnt = r_cnt + 1'b1;
          end
        end
      end
      S_RELEASE: begin
        if (!w_lock_s) begin
          w_nxt_state = S_RESET;
          w_nxt_rst   = ALL1;
          w_nxt_cnt   = '0;
          w_nxt_done  = 1'b0;
        end else if (r_cnt == C_STAG) begin
          w_nxt_rst   = r_rst << 1;
          w_nxt_cnt   = '0;
          w_nxt_state = (w_nxt_rst == '0) ? S_IDLE : S_RELEASE;
          w_nxt_done  = (w_nxt_rst == '0);
        end else begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
      S_IDLE: begin
        w_nxt_rst  = '0;
        w_nxt_cnt  = '0;
        w_nxt_done = 1'b1;
        if (!w_lock_s || soft_req) begin
          w_nxt_state = S_RESET;
          w_nxt_rst   = ALL1;
          w_nxt_done  = 1'b0;
        end
      end
      default: begin
        w_nxt_state = S_RESET;
        w_nxt_rst   = ALL1;
        w_nxt_cnt   = '0;
        w_nxt_done  = 1'b0;
      end
    endcase
  end

  assign reset      = r_rst;
  assign reset_done = r_done;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: each stimulus pushes the expected {reset,reset_done}
// transitions with their clock-edge index; a monitor pops them on change.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b1;
  logic       soft_req = 1'b0;
  logic [2:0] rst;
  logic       done;

  reset_sequencer #(
    .NUM_CH(3), .START_DLY(4), .HOLD_CYC(3), .STAGGER(2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pll_locked(pll_locked),
    .soft_req  (soft_req),
    .reset     (rst),
    .reset_done(done)
  );

  always #5 clk = ~clk;

  int n_edge = 0;
  always @(posedge clk) n_edge++;

  typedef struct {
    int         edge_n;
    logic [3:0] val;
  } exp_t;
  exp_t q[$];

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, n_edge);
    end
  endtask

  // Monitor: any change of {reset,reset_done} must match the next expectation.
  logic [3:0] mon_prev = 4'b1110;
  logic [3:0] mon_cur;
  exp_t       mon_e;
  bit         mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      mon_cur = {rst, done};
      if (mon_cur !== mon_prev) begin
        if (q.size() == 0) chk("spurious", 32'(mon_cur), 32'(mon_prev));
        else begin
          mon_e = q.pop_front();
          chk("val", 32'(mon_cur), 32'(mon_e.val));
          chk("edge", n_edge, mon_e.edge_n);
        end
        mon_prev = mon_cur;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int e, input logic [3:0] v);
    exp_t x;
    x.edge_n = e;
    x.val    = v;
    q.push_back(x);
  endtask

  // Staggered release with reset[0] falling on edge b.
  task automatic push_rel(input int b);
    push(b,     4'b1100);
    push(b + 2, 4'b1000);
    push(b + 4, 4'b0001);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (q.size() != 0 && n < max) begin
      tick();
      n++;
    end
    chk("drain", q.size(), 0);
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, e2, e3;
    repeat (3) tick();
    chk("rst_state", 32'({rst, done}), 32'(4'b1110));
    mon_en = 1'b1;

    // Power-up release
    tick(); e = n_edge; reset_n = 1'b1;
    push_rel(e + 9);
    drain(40);

    // Soft request from idle
    tick(); e = n_edge; soft_req = 1'b1;
    push(e + 1, 4'b1110);
    push_rel(e + 4);
    tick(); soft_req = 1'b0;
    drain(40);

    // Lock loss while reset=100
    tick(); e = n_edge; soft_req = 1'b1;
    push(e + 1, 4'b1110);
    push(e + 4, 4'b1100);
    push(e + 6, 4'b1000);
    tick(); soft_req = 1'b0;
    while (n_edge < e + 6) tick();
    pll_locked = 1'b0; e2 = n_edge;
    push(e2 + 2, 4'b0001);
    push(e2 + 3, 4'b1110);
    repeat (10) tick();
    e3 = n_edge; pll_locked = 1'b1;
    push_rel(e3 + 5);
    drain(40);

    // reset_n pulse mid-S_RESET restarts the full sequence
    tick(); e = n_edge; soft_req = 1'b1;
    push(e + 1, 4'b1110);
    tick(); soft_req = 1'b0;
    tick(); reset_n = 1'b0;
    #1 chk("rst_in_reset", 32'({rst, done}), 32'(4'b1110));
    repeat (3) tick();
    e = n_edge; reset_n = 1'b1;
    push_rel(e + 9);
    drain(40);

    // Asynchronous assertion from idle, then soft_req held through start/hold
    tick(); e = n_edge; reset_n = 1'b0;
    #1 chk("async_assert", 32'({rst, done}), 32'(4'b1110));
    push(e + 1, 4'b1110);
    repeat (2) tick();
    e = n_edge; reset_n = 1'b1; soft_req = 1'b1;
    push_rel(e + 9);
    while (n_edge < e + 8) tick();
    soft_req = 1'b0;
    drain(40);

    // soft_req and lock loss together in idle: hold waits for lock
    tick(); e = n_edge; soft_req = 1'b1; pll_locked = 1'b0;
    push(e + 1, 4'b1110);
    tick(); soft_req = 1'b0;
    repeat (6) tick();
    e = n_edge; pll_locked = 1'b1;
    push_rel(e + 4);
    drain(40);

    chk("q_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of reset channels, legal range 1..16.
REQ-002 SHALL have parameter START_DLY, default 256: power-up settle cycles before the hold phase, minimum 1.
REQ-003 SHALL have parameter HOLD_CYC, default 16: cycles all channels are held in reset, minimum 1.
REQ-004 SHALL have parameter STAGGER, default 8: cycles between successive channel releases, minimum 1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port pll_locked, input, 1 bit: clock-source lock indication; asynchronous to clk.
REQ-008 SHALL have port soft_req, input, 1 bit: synchronous single-cycle request to re-run the reset sequence.
REQ-009 SHALL have port reset, output, NUM_CH bits: active-high per-channel resets.
REQ-010 SHALL have port reset_done, output, 1 bit: high when all channels are released.

Function
REQ-011 SHALL pass reset_n through a 2-flop synchroniser (asynchronous assert, synchronous deassert) to form the internal reset rst_i.
REQ-012 SHALL pass pll_locked through a 2-flop synchroniser to form lock_s.
REQ-013 SHALL implement states S_START, S_RESET, S_RELEASE and S_IDLE; unused encodings SHALL go to S_RESET.
REQ-014 S_START SHALL hold all reset bits at 1, increment the counter, and enter S_RESET with the counter cleared on the edge where counter == START_DLY-1.
REQ-015 S_RESET SHALL hold all reset bits at 1, increment the counter only while lock_s=1, and enter S_RELEASE with the counter cleared on the edge where counter == HOLD_CYC-1 and lock_s=1.
REQ-016 On the S_RESET->S_RELEASE edge, reset[0] SHALL clear.
REQ-017 In S_RELEASE, reset[i] SHALL clear exactly STAGGER cycles after reset[i-1], in ascending index order.
REQ-018 On the edge that clears reset[NUM_CH-1], the block SHALL enter S_IDLE and set reset_done=1.
REQ-019 With NUM_CH=1, the block SHALL go directly from S_RESET to S_IDLE, clearing reset[0] and setting reset_done on the same edge.
REQ-020 S_IDLE SHALL keep all reset bits at 0, keep reset_done at 1 and keep the counter at 0.
REQ-021 soft_req=1 in S_IDLE SHALL, on the next edge, enter S_RESET, set all reset bits, clear reset_done and clear the counter.
REQ-022 soft_req SHALL be ignored in every state other than S_IDLE.
REQ-023 lock_s=0 in S_START, S_RELEASE or S_IDLE SHALL, on the next edge, enter S_RESET, set all reset bits, clear reset_done and clear the counter.
REQ-024 When lock_s=0 and soft_req=1 occur in the same cycle, the lock-loss behaviour SHALL take precedence.
REQ-025 The counter width SHALL be clog2(max(START_DLY, HOLD_CYC, STAGGER))+1 and the counter SHALL never wrap.

Reset
REQ-026 While rst_i is asserted, the block SHALL be in S_START, with counter=0, reset_done=0 and all reset bits at 1; reset bits SHALL assert asynchronously as soon as reset_n falls.
REQ-027 Assertion of reset_n at any point in the sequence SHALL abort the sequence and restart it from S_START after reset_n deasserts.

Structure
REQ-028 State encodings and the counter-width function SHALL live in a shared include/package, reset_seq_pkg.
REQ-029 The block SHALL contain one sub-module, sync_2ff, instantiated once for reset_n (async-assert mode) and once for pll_locked.
REQ-030 Parameter legality SHALL be checked at elaboration, with a fatal error on any out-of-range value.

Verification
All scenarios use NUM_CH=3, START_DLY=4, HOLD_CYC=3, STAGGER=2, and pll_locked=1 unless stated otherwise.
REQ-031 Power-up: release reset_n -> reset=3'b111 until the 9th clk edge after release; then reset[0] falls; reset[1] falls 2 edges later; reset[2] and the rise of reset_done occur 4 edges after reset[0] falls.
REQ-032 soft_req pulse in S_IDLE -> reset=3'b111 and reset_done=0 on the next edge; reset[0] falls 3 edges later; the release staggering then repeats as in REQ-031.
REQ-033 pll_locked falls during S_RELEASE (reset=3'b100) -> reset=3'b111 three edges later; the sequence stays in S_RESET until pll_locked returns, then HOLD_CYC+2 edges elapse before reset[0] falls.
REQ-034 reset_n pulsed low mid-S_RESET -> reset=3'b111 immediately without waiting for clk; the full START_DLY+HOLD_CYC sequence restarts.
REQ-035 soft_req held high during S_START and S_RESET -> no effect on timing; soft_req and pll_locked falling together in S_IDLE -> the sequence waits for lock before proceeding.
